bist_march_ctrl: RTL

BIST_MARCH_CTRL -- requirements
Module: bist_march_ctrl

---
 rtl/bist_march_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl -- March C- memory built-in self-test controller.
//
// Runs the March C- sequence against a synchronous single-port memory
// under test (MUT). The sequence is:
//   M0 up(w0)
//   M1 up(r0,w1)
//   M2 up(r1,w0)
//   M3 down(r0,w1)
//   M4 down(r1,w0)
//   M5 down(r0)
// Here "0" is all-zeros and "1" is all-ones.
//
// Each read element uses an RD cycle followed by a CMP cycle. The MUT
// returns read data during CMP, and the element's write-back is issued in
// that same CMP cycle. A full march takes 11*DEPTH cycles. done rises one
// edge after the last CMP.
//
// Optional feature (macro BIST_FAIL_ADDR_EN):
//   Adds the fail_addr and fail_elem outputs. They capture the address and
//   element index of the first mismatch.
//
// Parameters:
//   ADDR_W     MUT address width (DEPTH = 2**ADDR_W)
//   DATA_W     MUT data width
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      test request, sampled in IDLE and in DONE
//              (ignored while busy)
//   mem_rdata  MUT read data, valid one cycle after mem_re
//   mem_addr   MUT address
//   mem_wdata  MUT write data
//   mem_we     MUT write strobe
//   mem_re     MUT read strobe
//   busy       march in progress
//   done       march finished; held until the next start or reset
//   fail       sticky mismatch flag
//   fail_addr  (BIST_FAIL_ADDR_EN only) address of the first mismatch
//   fail_elem  (BIST_FAIL_ADDR_EN only) element index of the first mismatch
module bist_march_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              fail
`ifdef BIST_FAIL_ADDR_EN
  ,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [2:0] LAST_ELEM = 3'd5;

  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

  state_t            state_reg;
  logic [2:0]        elem_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Value expected on a read in element e. M2 and M4 read ones; every
  // other element reads zeros.
  function automatic logic [DATA_W-1:0] exp_pat(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  // Value written by element e. M1 and M3 write ones; M0, M2 and M4 write
  // zeros.
  function automatic logic [DATA_W-1:0] wr_pat(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  // M3..M5 walk addresses downward.
  function automatic logic is_down(input logic [2:0] e);
    return e >= 3'd3;
  endfunction

  logic [2:0]        elem_nxt;
  logic [ADDR_W-1:0] first_addr_nxt;
  logic              at_last;
  logic              mismatch;

  assign elem_nxt       = elem_reg + 3'd1;
  assign first_addr_nxt = is_down(elem_nxt) ? ADDR_MAX : '0;

  // The element ends on its boundary address. Address steps therefore
  // never wrap inside an element.
  assign at_last  = is_down(elem_reg) ? (addr_reg == '0) : (addr_reg == ADDR_MAX);
  assign mismatch = (mem_rdata != exp_pat(elem_reg));
  assign mem_addr = addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      elem_reg  <= '0;
      addr_reg  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
`ifdef BIST_FAIL_ADDR_EN
      fail_addr <= '0;
      fail_elem <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (state_reg == DONE && busy) begin
            // Extra cycle after the last CMP: hand over from busy to done.
            busy <= 1'b0;
            done <= 1'b1;
          end else if (start) begin
            state_reg <= WR;
            elem_reg  <= '0;
            addr_reg  <= '0;
            mem_wdata <= wr_pat(3'd0);
            mem_we    <= 1'b1;
            mem_re    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
`ifdef BIST_FAIL_ADDR_EN
            fail_addr <= '0;
            fail_elem <= '0;
`endif
          end
        end

        // Only M0 uses WR: one write per cycle, walking upward.
        WR: begin
          if (at_last) begin
            state_reg <= RD;
            elem_reg  <= elem_nxt;
            addr_reg  <= first_addr_nxt;
            mem_we    <= 1'b0;
            mem_re    <= 1'b1;
            mem_wdata <= '0;
          end else begin
            addr_reg <= addr_reg + 1'b1;
          end
        end

        // The read was issued during RD. Set up the CMP slot at the same
        // address: a write-back for M1-M4. M5 has nothing to write, so its
        // CMP slot re-issues the read, which leaves memory unchanged.
        RD: begin
          state_reg <= CMP;
          if (elem_reg == LAST_ELEM) begin
            mem_we <= 1'b0;
            mem_re <= 1'b1;
          end else begin
            mem_we    <= 1'b1;
            mem_re    <= 1'b0;
            mem_wdata <= wr_pat(elem_reg);
          end
        end

        CMP: begin
          if (mismatch) begin
            fail <= 1'b1;
`ifdef BIST_FAIL_ADDR_EN
            if (!fail) begin
              fail_addr <= addr_reg;
              fail_elem <= elem_reg;
            end
`endif
          end
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          if (at_last && elem_reg == LAST_ELEM) begin
            state_reg <= DONE;
            mem_re    <= 1'b0;
          end else begin
            state_reg <= RD;
            mem_re    <= 1'b1;
            if (at_last) begin
              elem_reg <= elem_nxt;
              addr_reg <= first_addr_nxt;
            end else if (is_down(elem_reg)) begin
              addr_reg <= addr_reg - 1'b1;
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
